// File: rtl/tocador_musica.sv
// Song playback sequencer: walks the song RAM from address 0, presenting each
// note on o_nota/o_toca for its stored tempo (in metronome half-beat ticks),
// with an optional silent gap between notes. Stops at the end-of-song flag
// or at the last RAM address.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// OCIOSO    | idle, waiting for i_inicia
// LE        | RAM address presented, waiting out the read latency
// CARREGA   | RAM data valid: end-of-song check, latch note and tempo
// TOCA      | note sounding, counting ticks up to the effective tempo
// PAUSA_GAP | silent gap between notes (down-counter)
// FIM       | playback finished, one-cycle completion pulse follows
module tocador_musica #(
  parameter int ADDR_W     = 8,
  parameter int GAP_CYCLES = 1000
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic              i_inicia,
  input  logic              i_para,
  input  logic              i_pausa,
  input  logic              i_tick,
  input  logic [3:0]        i_mem_nota,
  input  logic [3:0]        i_mem_tempo,
  input  logic              i_mem_fim,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [3:0]        o_nota,
  output logic              o_toca,
  output logic              o_ocupado,
  output logic              o_fim_pulso,
  output logic [2:0]        o_db_estado
);

  typedef enum logic [2:0] {
    OCIOSO    = 3'd0,
    LE        = 3'd1,
    CARREGA   = 3'd2,
    TOCA      = 3'd3,
    PAUSA_GAP = 3'd4,
    FIM       = 3'd5
  } estado_t;

  // Gap timer reloads with GAP_CYCLES-1 and ends at zero; kept at least
  // one bit wide so the design elaborates when the gap is disabled.
  localparam int GAP_LAST = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
  localparam int GAP_W    = (GAP_LAST > 0) ? $clog2(GAP_LAST + 1) : 1;

  estado_t           r_estado;
  estado_t           w_estado_prox;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [3:0]        r_nota;
  logic              r_toca;
  logic              r_fim_pulso;
  logic [3:0]        r_count;
  logic [3:0]        r_tempo_ef;
  logic [GAP_W-1:0]  r_gap_cnt;

  logic              w_abort;
  logic              w_start;
  logic              w_tick_ok;
  logic [3:0]        w_count_inc;
  logic              w_nota_fim;
  logic              w_ultimo;

  assign w_abort     = i_para && (r_estado != OCIOSO);
  assign w_start     = (r_estado == OCIOSO) && i_inicia && !i_para;
  assign w_tick_ok   = i_tick && !i_pausa;
  assign w_count_inc = r_count + 4'd1;
  assign w_nota_fim  = (r_estado == TOCA) && w_tick_ok && (w_count_inc == r_tempo_ef);
  assign w_ultimo    = &r_mem_addr;

  // State register
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_estado <= OCIOSO;
    end else begin
      r_estado <= w_estado_prox;
    end
  end

  // Next-state logic; abort overrides every transition
  always_comb begin
    w_estado_prox = r_estado;
    case (r_estado)
      OCIOSO:    if (w_start) w_estado_prox = LE;
      LE:        w_estado_prox = CARREGA;
      CARREGA:   w_estado_prox = i_mem_fim ? FIM : TOCA;
      TOCA: begin
        if (w_nota_fim) begin
          if (w_ultimo)             w_estado_prox = FIM;
          else if (GAP_CYCLES == 0) w_estado_prox = LE;
          else                      w_estado_prox = PAUSA_GAP;
        end
      end
      PAUSA_GAP: if (!i_pausa && (r_gap_cnt == '0)) w_estado_prox = LE;
      FIM:       w_estado_prox = OCIOSO;
      default:   w_estado_prox = OCIOSO;
    endcase
    if (w_abort) w_estado_prox = OCIOSO;
  end

  // Datapath: address, note, tick/gap counters and registered outputs
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_mem_addr  <= '0;
      r_nota      <= 4'd0;
      r_toca      <= 1'b0;
      r_fim_pulso <= 1'b0;
      r_count     <= 4'd0;
      r_tempo_ef  <= 4'd0;
      r_gap_cnt   <= '0;
    end else begin
      // Buzzer only while the note keeps sounding into the next cycle
      r_toca      <= (r_estado == TOCA) && (w_estado_prox == TOCA) &&
                     (r_nota != 4'd0) && !i_pausa;
      r_fim_pulso <= (r_estado == FIM) && !i_para;
      if (w_abort) begin
        r_mem_addr <= '0;
        r_nota     <= 4'd0;
      end else begin
        case (r_estado)
          OCIOSO: begin
            if (w_start) r_mem_addr <= '0;
          end
          CARREGA: begin
            if (!i_mem_fim) begin
              r_nota     <= i_mem_nota;
              r_tempo_ef <= (i_mem_tempo == 4'd0) ? 4'd1 : i_mem_tempo;
              r_count    <= 4'd0;
            end
          end
          TOCA: begin
            if (w_tick_ok) begin
              if (w_nota_fim) begin
                if (!w_ultimo) r_mem_addr <= r_mem_addr + ADDR_W'(1);
                r_gap_cnt <= GAP_W'(GAP_LAST);
              end else begin
                r_count <= w_count_inc;
              end
            end
          end
          PAUSA_GAP: begin
            if (!i_pausa && (r_gap_cnt != '0)) r_gap_cnt <= r_gap_cnt - GAP_W'(1);
          end
          FIM: begin
            r_nota <= 4'd0;
          end
          default: ;
        endcase
      end
    end
  end

  assign o_mem_addr  = r_mem_addr;
  assign o_nota      = r_nota;
  assign o_toca      = r_toca;
  assign o_fim_pulso = r_fim_pulso;
  assign o_ocupado   = (r_estado != OCIOSO);
  assign o_db_estado = r_estado;

endmodule
